multi_unit: RTL

Iterative unsigned mantissa multiplier that serves the IEEE754 `Multi` stage of the ALU. `Multi` presents two operands with a one-cycle trigger. `multi_unit` accepts 24-bit significands (hidden bit included), runs a fixed-latency shift-add loop, and returns the upper product bits with a sticky bit for rounding. It sits directly downstream of `Multi`'s `mul_data*_out` / `mul_trig_out` and feeds its `mul_result_in` / `mul_result_vld`.

---
 rtl/multi_unit.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/multi_unit.sv
// multi_unit -- iterative unsigned 24x24 significand multiplier for the
// IEEE754 Multi stage. A one-cycle trigger in IDLE latches both operands,
// then a fixed-length shift-add loop builds the 48-bit product P. On
// completion the result {P[47:17], |P[16:0]} is registered and a one-cycle
// valid pulse is issued.
//
// Build option: define MULTI_UNIT_RADIX4_EN to consume two multiplier bits
// per cycle (12 iterations, result after edge T+13) instead of one
// (24 iterations, result after edge T+25). The result value is identical.
//
// Ports:
//   sys_clk         in   1   clock, rising edge
//   sys_rst         in   1   asynchronous active-high reset
//   mul_data1_in    in  32   multiplicand, bits [23:0] used
//   mul_data2_in    in  32   multiplier, bits [23:0] used
//   mul_trig_in     in   1   start pulse, sampled only in IDLE
//   mul_result_out  out 32   {P[47:17], sticky}, held until next completion
//   mul_result_vld  out  1   one-cycle pulse when mul_result_out updates
//   busy            out  1   high while the loop is running
module multi_unit (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [31:0] mul_data1_in,
  input  logic [31:0] mul_data2_in,
  input  logic        mul_trig_in,
  output logic [31:0] mul_result_out,
  output logic        mul_result_vld,
  output logic        busy
);

  typedef enum logic {
    IDLE,
    CALC
  } state_t;

`ifdef MULTI_UNIT_RADIX4_EN
  localparam logic [4:0] LAST_CNT = 5'd12;
`else
  localparam logic [4:0] LAST_CNT = 5'd24;
`endif

  state_t      state;
  state_t      state_nxt;
  logic        start;
  logic        done;
  logic [23:0] a_q;
  logic [23:0] b_q;
  logic [47:0] acc;
  logic [47:0] addend;
  logic [4:0]  cnt;

`ifdef MULTI_UNIT_RADIX4_EN
  logic [25:0] a3_q;
  logic [25:0] pp;
`endif

  // Operand bits [31:24] are intentionally ignored.
  logic unused_upper;
  assign unused_upper = ^{mul_data1_in[31:24], mul_data2_in[31:24]};

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The loop finishes one edge after the last iteration so the registered
  // result is taken from the fully accumulated product.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (mul_trig_in) begin
          start     = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (cnt == LAST_CNT) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef MULTI_UNIT_RADIX4_EN
  always_comb begin
    pp     = '0;
    addend = '0;
    case (b_q[1:0])
      2'd1:    pp = {2'b00, a_q};
      2'd2:    pp = {1'b0, a_q, 1'b0};
      2'd3:    pp = a3_q;
      default: pp = '0;
    endcase
    addend = {22'd0, pp} << {cnt, 1'b0};
  end
`else
  always_comb begin
    addend = '0;
    if (b_q[0]) begin
      addend = {24'd0, a_q} << cnt;
    end
  end
`endif

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      a_q            <= '0;
      b_q            <= '0;
      acc            <= '0;
      cnt            <= '0;
      mul_result_out <= '0;
      mul_result_vld <= 1'b0;
      busy           <= 1'b0;
`ifdef MULTI_UNIT_RADIX4_EN
      a3_q           <= '0;
`endif
    end else begin
      mul_result_vld <= done;
      busy           <= (state_nxt == CALC);
      if (start) begin
        a_q  <= mul_data1_in[23:0];
        b_q  <= mul_data2_in[23:0];
        acc  <= '0;
        cnt  <= '0;
`ifdef MULTI_UNIT_RADIX4_EN
        a3_q <= {2'b00, mul_data1_in[23:0]} + {1'b0, mul_data1_in[23:0], 1'b0};
`endif
      end else if (state == CALC && !done) begin
        acc <= acc + addend;
`ifdef MULTI_UNIT_RADIX4_EN
        b_q <= b_q >> 2;
`else
        b_q <= b_q >> 1;
`endif
        cnt <= cnt + 5'd1;
      end
      if (done) begin
        mul_result_out <= {acc[47:17], |acc[16:0]};
      end
    end
  end

endmodule
